// File: rtl/jump_key_debouncer_pkg.sv
// rtl/jump_key_debouncer_pkg.sv - shared input-block package: key FSM encodings and debounce defaults
package jump_key_debouncer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT           = 32;
  localparam int unsigned PRESS_CNT_W             = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // The button counts as down until the release has itself been debounced.
  function automatic logic key_is_down(input key_state_e state);
    return (state == PRESSED) || (state == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer for asynchronous button inputs
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/jump_key_debouncer.sv
// rtl/jump_key_debouncer.sv - debounced jump button with one-deep pending-press flag and press counter
module jump_key_debouncer
  import jump_key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic                   proc_clk,
  input  logic                   reset,
  input  logic                   raw_key,
  input  logic                   key_ack,
  output logic                   jump_key,
  output logic                   key_level,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [PRESS_CNT_W-1:0] PRESS_ONE  = PRESS_CNT_W'(1);
  localparam logic [PRESS_CNT_W-1:0] PRESS_MAX  = '1;

  logic                   key_sync;
  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   level_q, level_d;
  logic [PRESS_CNT_W-1:0] count_q, count_d;
  logic                   accept;

  sync_2ff u_sync (
    .clk_i   (proc_clk),
    .reset_i (reset),
    .d_i     (raw_key),
    .q_o     (key_sync)
  );

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      level_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!key_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_sync) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new press outranks a same-cycle acknowledge so it is never lost.
  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (key_ack) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != PRESS_MAX)) begin
      count_d = count_q + PRESS_ONE;
    end
  end

  assign level_d     = key_is_down(state_d);
  assign jump_key    = pending_q;
  assign key_level   = level_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_jump_key_debouncer.sv
// tb/tb_jump_key_debouncer.sv - directed self-checking bench for jump_key_debouncer with DEBOUNCE_CYCLES=4
module tb_jump_key_debouncer;

  logic       proc_clk = 1'b0;
  logic       reset;
  logic       raw_key;
  logic       key_ack;
  logic       jump_key;
  logic       key_level;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  jump_key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (32)
  ) dut (
    .proc_clk    (proc_clk),
    .reset       (reset),
    .raw_key     (raw_key),
    .key_ack     (key_ack),
    .jump_key    (jump_key),
    .key_level   (key_level),
    .press_count (press_count)
  );

  always #5 proc_clk = ~proc_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge proc_clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic jk, input logic lvl, input logic [7:0] cnt);
    check_eq({tag, ".jump_key"},    32'(jump_key),    32'(jk));
    check_eq({tag, ".key_level"},   32'(key_level),   32'(lvl));
    check_eq({tag, ".press_count"}, 32'(press_count), 32'(cnt));
  endtask

  initial begin
    reset   = 1'b1;
    raw_key = 1'b0;
    key_ack = 1'b0;
    tick(2);
    check_outs("reset", 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    tick(2);

    // bounce: 3 high, 2 low, 3 high, then low
    raw_key = 1'b1; tick(3);
    raw_key = 1'b0; tick(2);
    raw_key = 1'b1; tick(3);
    raw_key = 1'b0; tick(12);
    check_outs("bounce", 1'b0, 1'b0, 8'd0);

    // high for exactly DEBOUNCE_CYCLES is still rejected
    raw_key = 1'b1; tick(4);
    raw_key = 1'b0; tick(12);
    check_outs("pulse4", 1'b0, 1'b0, 8'd0);

    // clean press accepted on the 7th edge
    raw_key = 1'b1;
    tick(6);
    check_outs("press_e6", 1'b0, 1'b0, 8'd0);
    tick(1);
    check_outs("press_e7", 1'b1, 1'b1, 8'd1);

    key_ack = 1'b1; tick(1); key_ack = 1'b0;
    check_eq("ack1.jump_key", 32'(jump_key), 32'd0);
    key_ack = 1'b1; tick(1); key_ack = 1'b0;
    check_outs("ack2", 1'b0, 1'b1, 8'd1);

    // release, then re-press with ack on the accept edge
    raw_key = 1'b0;
    tick(6);
    check_eq("release_e6.key_level", 32'(key_level), 32'd1);
    tick(1);
    check_eq("release_e7.key_level", 32'(key_level), 32'd0);
    raw_key = 1'b1;
    tick(6);
    check_eq("repress_e6.jump_key", 32'(jump_key), 32'd0);
    key_ack = 1'b1; tick(1); key_ack = 1'b0;
    check_outs("collision", 1'b1, 1'b1, 8'd2);
    key_ack = 1'b1; tick(1); key_ack = 1'b0;
    check_eq("post_collision_ack.jump_key", 32'(jump_key), 32'd0);

    // saturation: 260 press/release cycles without ack
    raw_key = 1'b0; tick(8);
    for (int i = 0; i < 252; i++) begin
      raw_key = 1'b1; tick(8);
      raw_key = 1'b0; tick(8);
    end
    check_eq("sat_254.press_count", 32'(press_count), 32'd254);
    raw_key = 1'b1; tick(8);
    raw_key = 1'b0; tick(8);
    check_eq("sat_255.press_count", 32'(press_count), 32'd255);
    for (int i = 0; i < 7; i++) begin
      raw_key = 1'b1; tick(8);
      raw_key = 1'b0; tick(8);
    end
    check_outs("sat_hold", 1'b1, 1'b0, 8'd255);

    // reset in PRESS_WAIT with cnt=2, colliding with key_ack
    raw_key = 1'b1;
    tick(5);
    reset   = 1'b1;
    key_ack = 1'b1;
    tick(1);
    reset   = 1'b0;
    key_ack = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0, 8'd0);
    tick(6);
    check_outs("after_reset_e6", 1'b0, 1'b0, 8'd0);
    tick(1);
    check_outs("after_reset_e7", 1'b1, 1'b1, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_key_debouncer.md
JUMP_KEY_DEBOUNCER -- requirements
Module: jump_key_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz proc clock); minimum legal value 1.
REQ-002 SHALL have parameter CNT_W, default 32; width of the debounce counter.
REQ-003 SHALL have port proc_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port raw_key  input  1  asynchronous, bouncing jump button level (1 = pressed).
REQ-006 SHALL have port key_ack  input  1  one-cycle pulse from the interrupt stage when it has taken the pending press.
REQ-007 SHALL have port jump_key  output  1  registered "press pending" flag, fed to the interrupt controller's jump_key input.
REQ-008 SHALL have port key_level  output  1  registered debounced button level.
REQ-009 SHALL have port press_count  output  8  count of accepted presses since reset, saturating.

Function
REQ-010 SHALL pass raw_key through a 2-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: sync2=1 -> PRESS_WAIT, cnt<=0; otherwise stay.
REQ-013 PRESS_WAIT: sync2=0 -> IDLE (bounce rejected, no press); else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED; else cnt<=cnt+1.
REQ-014 PRESSED: sync2=0 -> RELEASE_WAIT, cnt<=0; otherwise stay.
REQ-015 RELEASE_WAIT: sync2=1 -> PRESSED (no new press); else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-016 key_level SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 The PRESS_WAIT->PRESSED transition SHALL be the only "accepted press" event.
REQ-018 An accepted press SHALL set pending (jump_key<=1) on the same edge.
REQ-019 key_ack with pending=1 and no accepted press on that edge SHALL clear pending.
REQ-020 Accepted press and key_ack on the same edge: pending SHALL end at 1 (set wins).
REQ-021 key_ack while pending=0 SHALL be ignored.
REQ-022 Further accepted presses while pending=1 SHALL leave pending at 1 (no queueing beyond one).
REQ-023 Each accepted press SHALL increment press_count by 1, holding at 255 (no wrap).
REQ-024 Latency: sync2 goes high at edge N; jump_key SHALL read 1 after edge N+1+DEBOUNCE_CYCLES when raw_key stays high.
REQ-025 A high pulse on sync2 of DEBOUNCE_CYCLES cycles or fewer SHALL never produce a press.
REQ-026 cnt SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-027 On a proc_clk edge with reset=1: state=IDLE, cnt=0, sync1=sync2=0, jump_key=0, key_level=0, press_count=0.
REQ-028 Reset SHALL take priority over every other event, including a press completing or key_ack on the same edge.
REQ-029 Reset SHALL be fully effective from any state, including mid-debounce; no press SHALL be reported from a press in progress at reset.

Structure
REQ-030 State encodings and the DEBOUNCE_CYCLES default SHALL live in the shared input package used by the IO controller blocks.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other buttons.
REQ-032 Otherwise a single module, no memories; target 120-250 lines of RTL.

Verification (bench overrides DEBOUNCE_CYCLES=4)
REQ-033 Clean press: raw_key high from cycle 0 and held -> jump_key=1 and press_count=1 after 7 edges; key_level=1 on the same edge.
REQ-034 Bounce: raw_key high 3 cycles, low 2, high 3, low -> jump_key stays 0, press_count stays 0.
REQ-035 Ack handshake: after a clean press, pulse key_ack 1 cycle -> jump_key=0 on the next edge; a second key_ack -> no change.
REQ-036 Set/ack collision: release, re-press, and key_ack on the accept edge -> jump_key stays 1, press_count=2.
REQ-037 Saturation: 260 clean press/release cycles without ack -> press_count=255, jump_key=1.
REQ-038 Reset mid-debounce: assert reset in PRESS_WAIT with cnt=2 -> all outputs 0 next edge; with raw_key still high, the press is accepted 7 edges after reset deasserts.
